dr_sched: RTL and testbench

DR_SCHED -- requirements
Module: dr_sched

---
 rtl/dr_pkg.sv | 15 +
 rtl/dr_rr_arb.sv | 27 ++
 rtl/dr_sched.sv | 132 +++++++++++++
 tb/tb_dr_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dr_pkg.sv
// Shared widths and FSM state encoding for the drinks-machine order scheduler.
package dr_pkg;

   localparam int DR_PAY_W   = 10;
   localparam int DR_CODE_W  = 8;
   localparam int DR_DRINK_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } dr_state_e;

endpackage

// File: rtl/dr_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module dr_rr_arb #(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    ptr_i,
   output logic [IW-1:0]    grant_o,
   output logic             any_o
);

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      int idx;
      grant_o = '0;
      any_o   = 1'b0;
      idx     = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr_i) + k) % N_REQ;
         if (req_i[idx]) begin
            grant_o = IW'(idx);
            any_o   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dr_sched.sv
// Serialises orders from N_REQ panels onto one drinks machine, one in flight.
//   state    | meaning
//   ST_IDLE  | pick a panel round-robin, pulse its req_ready, latch payload
//   ST_ISSUE | strobe m_valid for one cycle with the latched order
//   ST_WAIT  | wait for m_done, give up after TIMEOUT cycles
//   ST_RESP  | rsp_valid for one cycle, advance round-robin pointer
module dr_sched
   import dr_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*DR_PAY_W-1:0]     req_pay_in,
   input  logic [N_REQ*DR_CODE_W-1:0]    req_code,
   output logic [N_REQ-1:0]              req_ready,
   output logic                          m_valid,
   output logic [DR_PAY_W-1:0]           m_pay_in,
   output logic [DR_CODE_W-1:0]          m_code,
   input  logic                          m_done,
   input  logic [DR_DRINK_W-1:0]         m_drink,
   input  logic                          m_error,
   output logic                          rsp_valid,
   output logic [$clog2(N_REQ)-1:0]      rsp_id,
   output logic [DR_DRINK_W-1:0]         rsp_drink,
   output logic                          rsp_error,
   output logic                          busy
);

   localparam int IW = $clog2(N_REQ);
   localparam int TW = $clog2(TIMEOUT + 1);

   dr_state_e              state_q;
   logic [IW-1:0]          rr_ptr_q, rr_ptr_d, grant_q;
   logic [TW-1:0]          timer_q;
   logic [DR_PAY_W-1:0]    pay_q;
   logic [DR_CODE_W-1:0]   code_q;
   logic [N_REQ-1:0]       req_ready_q;
   logic                   m_valid_q, rsp_valid_q, rsp_error_q, busy_q;
   logic [IW-1:0]          rsp_id_q;
   logic [DR_DRINK_W-1:0]  rsp_drink_q;
   logic [IW-1:0]          arb_grant;
   logic                   arb_any;

   dr_rr_arb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (arb_grant),
      .any_o   (arb_any)
   );

   assign rr_ptr_d = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         timer_q     <= '0;
         pay_q       <= '0;
         code_q      <= '0;
         req_ready_q <= '0;
         m_valid_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_drink_q <= '0;
         rsp_error_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         req_ready_q <= '0;
         m_valid_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (arb_any) begin
                  grant_q     <= arb_grant;
                  pay_q       <= req_pay_in[arb_grant*DR_PAY_W +: DR_PAY_W];
                  code_q      <= req_code[arb_grant*DR_CODE_W +: DR_CODE_W];
                  req_ready_q <= N_REQ'(1) << arb_grant;
                  state_q     <= ST_ISSUE;
                  busy_q      <= 1'b1;
               end
            end
            ST_ISSUE: begin
               m_valid_q <= 1'b1;
               timer_q   <= '0;
               state_q   <= ST_WAIT;
            end
            ST_WAIT: begin
               // m_done is checked first so it wins in the final timeout cycle.
               if (m_done) begin
                  rsp_valid_q <= 1'b1;
                  rsp_id_q    <= grant_q;
                  rsp_drink_q <= m_drink;
                  rsp_error_q <= m_error;
                  state_q     <= ST_RESP;
               end else if (timer_q == TW'(TIMEOUT - 1)) begin
                  rsp_valid_q <= 1'b1;
                  rsp_id_q    <= grant_q;
                  rsp_drink_q <= '0;
                  rsp_error_q <= 1'b1;
                  state_q     <= ST_RESP;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            ST_RESP: begin
               rr_ptr_q <= rr_ptr_d;
               state_q  <= ST_IDLE;
               busy_q   <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign m_valid   = m_valid_q;
   assign m_pay_in  = pay_q;
   assign m_code    = code_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_drink = rsp_drink_q;
   assign rsp_error = rsp_error_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_dr_sched.sv
// Directed bench for dr_sched: single order, contention, timeout, tie, reset abort.
module tb_dr_sched;
   import dr_pkg::*;

   localparam int N_REQ   = 4;
   localparam int TIMEOUT = 15;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [N_REQ-1:0]           req_valid;
   logic [N_REQ*DR_PAY_W-1:0]  req_pay_in;
   logic [N_REQ*DR_CODE_W-1:0] req_code;
   logic [N_REQ-1:0]           req_ready;
   logic                       m_valid;
   logic [DR_PAY_W-1:0]        m_pay_in;
   logic [DR_CODE_W-1:0]       m_code;
   logic                       m_done;
   logic [DR_DRINK_W-1:0]      m_drink;
   logic                       m_error;
   logic                       rsp_valid;
   logic [1:0]                 rsp_id;
   logic [DR_DRINK_W-1:0]      rsp_drink;
   logic                       rsp_error;
   logic                       busy;

   int n_vec = 0;
   int n_err = 0;

   dr_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_pay_in (req_pay_in),
      .req_code   (req_code),
      .req_ready  (req_ready),
      .m_valid    (m_valid),
      .m_pay_in   (m_pay_in),
      .m_code     (m_code),
      .m_done     (m_done),
      .m_drink    (m_drink),
      .m_error    (m_error),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_drink  (rsp_drink),
      .rsp_error  (rsp_error),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_panel(input int i, input logic [9:0] pay, input logic [7:0] code);
      req_pay_in[i*DR_PAY_W +: DR_PAY_W]   = pay;
      req_code[i*DR_CODE_W +: DR_CODE_W]   = code;
   endtask

   task automatic wait_ready(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (req_ready != '0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("ready_wait", 32'(ok), 32'd1);
   endtask

   logic [9:0] pay_tab [4];
   logic [7:0] code_tab [4];
   int         cnt;
   bit         seen;

   initial begin
      rst        = 1'b0;
      req_valid  = '0;
      req_pay_in = '0;
      req_code   = '0;
      m_done     = 1'b0;
      m_drink    = '0;
      m_error    = 1'b0;
      pay_tab[0] = 10'd0;   code_tab[0] = 8'h10;
      pay_tab[1] = 10'd25;  code_tab[1] = 8'h11;
      pay_tab[2] = 10'd512; code_tab[2] = 8'h12;
      pay_tab[3] = 10'd1023; code_tab[3] = 8'h13;

      tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_mvalid", 32'(m_valid), 0);
      chk("rst_rspvalid", 32'(rsp_valid), 0);
      chk("rst_mpay", 32'(m_pay_in), 0);
      rst = 1'b1;
      tick();

      // spurious m_done in IDLE
      m_done = 1'b1; m_drink = 8'h33; m_error = 1'b1;
      tick();
      m_done = 1'b0; m_error = 1'b0;
      tick();
      chk("spur_rspvalid", 32'(rsp_valid), 0);
      chk("spur_rspdrink", 32'(rsp_drink), 0);
      chk("spur_rsperr", 32'(rsp_error), 0);
      chk("spur_busy", 32'(busy), 0);
      chk("spur_mvalid", 32'(m_valid), 0);

      // single order, panel 2
      set_panel(2, 10'd150, 8'h05);
      req_valid = 4'b0100;
      tick();
      chk("one_ready", 32'(req_ready), 32'b0100);
      chk("one_busy", 32'(busy), 1);
      chk("one_mvalid_t0", 32'(m_valid), 0);
      req_valid = '0;
      tick();
      chk("one_mvalid_t1", 32'(m_valid), 1);
      chk("one_mpay", 32'(m_pay_in), 150);
      chk("one_mcode", 32'(m_code), 32'h05);
      chk("one_ready_t1", 32'(req_ready), 0);
      tick();
      chk("one_mvalid_t2", 32'(m_valid), 0);
      tick();
      tick();
      m_done = 1'b1; m_drink = 8'h05; m_error = 1'b0;
      tick();
      m_done = 1'b0;
      chk("one_rspvalid", 32'(rsp_valid), 1);
      chk("one_rspid", 32'(rsp_id), 2);
      chk("one_rspdrink", 32'(rsp_drink), 32'h05);
      chk("one_rsperr", 32'(rsp_error), 0);
      tick();
      chk("one_rspvalid_end", 32'(rsp_valid), 0);
      chk("one_hold_drink", 32'(rsp_drink), 32'h05);
      chk("one_hold_id", 32'(rsp_id), 2);
      chk("one_busy_end", 32'(busy), 0);

      // contention from reset: all four always pending
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_panel(i, pay_tab[i], code_tab[i]);
      req_valid = 4'b1111;
      tick();
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         int g;
         g = k % 4;
         wait_ready(10);
         chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(1) << g);
         tick();
         chk($sformatf("rr%0d_mvalid", k), 32'(m_valid), 1);
         chk($sformatf("rr%0d_mpay", k), 32'(m_pay_in), 32'(pay_tab[g]));
         chk($sformatf("rr%0d_mcode", k), 32'(m_code), 32'(code_tab[g]));
         chk($sformatf("rr%0d_noready", k), 32'(req_ready), 0);
         tick();
         m_done = 1'b1; m_drink = 8'h40 + 8'(g); m_error = 1'b0;
         tick();
         m_done = 1'b0;
         chk($sformatf("rr%0d_rspvalid", k), 32'(rsp_valid), 1);
         chk($sformatf("rr%0d_rspid", k), 32'(rsp_id), 32'(g));
         chk($sformatf("rr%0d_rspdrink", k), 32'(rsp_drink), 32'h40 + 32'(g));
      end
      req_valid = '0;
      tick(); tick();

      // timeout, panel 1
      set_panel(1, 10'd300, 8'h22);
      req_valid = 4'b0010;
      wait_ready(10);
      chk("to_ready", 32'(req_ready), 32'b0010);
      req_valid = '0;
      tick();
      chk("to_mvalid", 32'(m_valid), 1);
      cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         cnt++;
         if (rsp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("to_seen", 32'(seen), 1);
      chk("to_cycles", 32'(cnt), TIMEOUT);
      chk("to_rspid", 32'(rsp_id), 1);
      chk("to_rspdrink", 32'(rsp_drink), 0);
      chk("to_rsperr", 32'(rsp_error), 1);
      tick(); tick();

      // tie: m_done in the last WAIT cycle, panel 2
      req_valid = 4'b0100;
      wait_ready(10);
      chk("tie_ready", 32'(req_ready), 32'b0100);
      req_valid = '0;
      tick();
      chk("tie_mvalid", 32'(m_valid), 1);
      repeat (TIMEOUT - 1) tick();
      chk("tie_pre_rsp", 32'(rsp_valid), 0);
      m_done = 1'b1; m_drink = 8'h07; m_error = 1'b0;
      tick();
      m_done = 1'b0;
      chk("tie_rspvalid", 32'(rsp_valid), 1);
      chk("tie_rspdrink", 32'(rsp_drink), 32'h07);
      chk("tie_rsperr", 32'(rsp_error), 0);
      chk("tie_rspid", 32'(rsp_id), 2);
      tick(); tick();

      // reset in WAIT, panel 1 granted via wrap from ptr 3
      set_panel(1, 10'd77, 8'h21);
      req_valid = 4'b0010;
      wait_ready(10);
      chk("rw_ready", 32'(req_ready), 32'b0010);
      req_valid = '0;
      tick();
      tick();
      chk("rw_busy_wait", 32'(busy), 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("rw_busy", 32'(busy), 0);
      chk("rw_rspvalid", 32'(rsp_valid), 0);
      chk("rw_mvalid", 32'(m_valid), 0);
      m_done = 1'b1; m_drink = 8'h55; m_error = 1'b1;
      tick();
      m_done = 1'b0; m_error = 1'b0;
      chk("rw_late_rspvalid", 32'(rsp_valid), 0);
      chk("rw_late_rspdrink", 32'(rsp_drink), 0);
      chk("rw_late_busy", 32'(busy), 0);
      req_valid = 4'b1111;
      tick();
      chk("rw_next_grant", 32'(req_ready), 32'b0001);
      req_valid = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
